// File: rtl/alu_issue_stage.sv
// Two-register issue/retire stage in front of the combinational ALU and Shifter.
// Stage 1 drives both units; stage 2 captures the selected result, flags and tag.
module alu_issue_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic             alu_invert_a,
  output logic             alu_invert_b,
  output logic [1:0]       alu_operation,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             sft_left_right,
  output logic [4:0]       sft_shamt,
  output logic [31:0]      sft_src,
  input  logic [31:0]      sft_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       ops_done
);

  typedef struct packed {
    logic       inv_a;
    logic       inv_b;
    logic [1:0] op;
    logic       is_shift;
    logic       left_right;
    logic       illegal;
  } dec_t;

  dec_t             dec, s1_dec;
  logic [31:0]      s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic [2:1]       vld_pipe;
  logic             adv2, accept, retire;
  logic [31:0]      s2_result_d;
  logic             s2_zero_d, s2_ovf_d;

  always_comb begin
    dec = '0;
    unique case (in_funct)
      4'b0000: dec.op = 2'b00;
      4'b0001: dec.op = 2'b01;
      4'b0010: dec.op = 2'b10;
      4'b0110: begin dec.inv_b = 1'b1; dec.op = 2'b10; end
      4'b0111: begin dec.inv_b = 1'b1; dec.op = 2'b11; end
      4'b1100: begin dec.inv_a = 1'b1; dec.inv_b = 1'b1; dec.op = 2'b00; end
      4'b1101: begin dec.inv_a = 1'b1; dec.inv_b = 1'b1; dec.op = 2'b01; end
      4'b1000: begin dec.is_shift = 1'b1; dec.left_right = 1'b1; end
      4'b1001: dec.is_shift = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // in_ready looks through to out_ready so a full pipe still streams at 1 op/cycle
  assign adv2     = vld_pipe[1] && (!vld_pipe[2] || out_ready);
  assign in_ready = !vld_pipe[1] || adv2;
  assign accept   = in_valid && in_ready;
  assign retire   = vld_pipe[2] && out_ready;

  assign alu_src1       = s1_a;
  assign alu_src2       = s1_b;
  assign alu_invert_a   = s1_dec.inv_a;
  assign alu_invert_b   = s1_dec.inv_b;
  assign alu_operation  = s1_dec.op;
  assign sft_left_right = s1_dec.left_right;
  assign sft_shamt      = s1_b[4:0];
  assign sft_src        = s1_a;

  always_comb begin
    s2_result_d = alu_result;
    s2_zero_d   = alu_zero;
    s2_ovf_d    = alu_overflow;
    if (s1_dec.illegal) begin
      s2_result_d = '0;
      s2_zero_d   = 1'b1;
      s2_ovf_d    = 1'b0;
    end else if (s1_dec.is_shift) begin
      s2_result_d = sft_result;
      s2_zero_d   = (sft_result == '0);
      s2_ovf_d    = 1'b0;
    end
  end

  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_dec       <= '0;
      s1_tag       <= '0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      ops_done     <= '0;
    end else begin
      if (accept) begin
        vld_pipe[1] <= 1'b1;
        s1_a        <= in_a;
        s1_b        <= in_b;
        s1_dec      <= dec;
        s1_tag      <= in_tag;
      end else if (adv2) begin
        vld_pipe[1] <= 1'b0;
      end
      if (adv2) begin
        vld_pipe[2]  <= 1'b1;
        out_result   <= s2_result_d;
        out_zero     <= s2_zero_d;
        out_overflow <= s2_ovf_d;
        out_illegal  <= s1_dec.illegal;
        out_tag      <= s1_tag;
      end else if (retire) begin
        vld_pipe[2] <= 1'b0;
      end
      if (retire) ops_done <= ops_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU/Shifter stubs plus a queue-based
// reference of in-flight operations, directed cases then random traffic.
module tb_alu_issue_stage;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_funct;
  logic [31:0] in_a, in_b;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [31:0] alu_src1, alu_src2, alu_result, sft_src, sft_result, out_result;
  logic alu_invert_a, alu_invert_b, alu_zero, alu_overflow, sft_left_right;
  logic [1:0] alu_operation;
  logic [4:0] sft_shamt;
  logic out_zero, out_overflow, out_illegal;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  alu_issue_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_invert_a(alu_invert_a),
    .alu_invert_b(alu_invert_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .sft_left_right(sft_left_right), .sft_shamt(sft_shamt), .sft_src(sft_src),
    .sft_result(sft_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_illegal(out_illegal), .out_tag(out_tag), .ops_done(ops_done)
  );

  // Combinational ALU: bit-inversion plus adder with carry-in from invert_b
  logic [31:0] a_eff, b_eff, sum, r;
  logic v;
  always_comb begin
    a_eff = alu_invert_a ? ~alu_src1 : alu_src1;
    b_eff = alu_invert_b ? ~alu_src2 : alu_src2;
    sum   = a_eff + b_eff + {31'd0, alu_invert_b};
    v     = (a_eff[31] == b_eff[31]) && (sum[31] != a_eff[31]);
    case (alu_operation)
      2'b00:   r = a_eff & b_eff;
      2'b01:   r = a_eff | b_eff;
      2'b10:   r = sum;
      default: r = {31'd0, sum[31] ^ v};
    endcase
    alu_result   = r;
    alu_zero     = (r == 32'd0);
    alu_overflow = (alu_operation == 2'b10) && v;
  end
  assign sft_result = sft_left_right ? (sft_src << sft_shamt) : (sft_src >> sft_shamt);

  typedef struct {
    logic [31:0] res;
    logic zero, ovf, ill;
    logic [TAG_W-1:0] tag;
    int acc;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] ops_m = 8'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, b,
                                 input logic [TAG_W-1:0] t, input int acc);
    exp_t e;
    logic [31:0] x;
    e.ovf = 1'b0; e.ill = 1'b0; e.tag = t; e.acc = acc;
    case (f)
      4'h0: x = a & b;
      4'h1: x = a | b;
      4'h2: begin x = a + b; e.ovf = (a[31] == b[31]) && (x[31] != a[31]); end
      4'h6: begin x = a - b; e.ovf = (a[31] != b[31]) && (x[31] != a[31]); end
      4'h7: x = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: x = ~(a | b);
      4'hD: x = ~(a & b);
      4'h8: x = a << b[4:0];
      4'h9: x = a >> b[4:0];
      default: begin x = 32'd0; e.ill = 1'b1; end
    endcase
    e.res = x; e.zero = (x == 32'd0);
    return e;
  endfunction

  // One clock: check against the model, update it with this cycle's handshakes, step
  task automatic cycle();
    logic acc_now, ret_now;
    #1;
    if (rst_n) begin
      chk("in_ready", in_ready, (q.size() < 2 || out_ready));
      chk("out_valid", out_valid, (q.size() >= 2 || (q.size() == 1 && cyc >= q[0].acc + 2)));
      chk("ops_done", ops_done, ops_m);
      if (out_valid && q.size() > 0) begin
        chk("res", out_result, q[0].res);
        chk("flags", {out_zero, out_overflow, out_illegal}, {q[0].zero, q[0].ovf, q[0].ill});
        chk("tag", out_tag, q[0].tag);
      end
      ret_now = out_valid && out_ready;
      acc_now = in_valid && in_ready;
      if (ret_now && q.size() > 0) begin
        void'(q.pop_front());
        ops_m = ops_m + 8'd1;
      end
      if (acc_now) q.push_back(model(in_funct, in_a, in_b, in_tag, cyc));
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      ops_m = 8'd0;
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [31:0] a, b, input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_funct = f; in_a = a; in_b = b; in_tag = t;
  endtask

  // Single op through an empty pipe with out_ready high; literal expectations
  task automatic run_one(input string nm, input logic [3:0] f, input logic [31:0] a, b,
                         input logic [TAG_W-1:0] t, input logic [31:0] xr,
                         input logic xz, xo, xi);
    out_ready = 1'b1;
    drive(f, a, b, t);
    cycle();
    in_valid = 1'b0;
    chk({nm, "_lat0"}, out_valid, 1'b0);
    cycle();
    chk({nm, "_lat1"}, out_valid, 1'b1);
    chk({nm, "_res"}, out_result, xr);
    chk({nm, "_zoi"}, {out_zero, out_overflow, out_illegal}, {xz, xo, xi});
    chk({nm, "_tag"}, out_tag, t);
    cycle();
  endtask

  logic [3:0] legal [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD, 4'h8, 4'h9};

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = 4'h0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", {out_result, out_zero, out_overflow, out_illegal, out_tag}, '0);
    chk("rst_ops", ops_done, 8'd0);
    chk("rst_alu", {alu_src1, alu_src2, alu_invert_a, alu_invert_b, alu_operation}, '0);
    chk("rst_sft", {sft_left_right, sft_shamt, sft_src}, '0);
    rst_n = 1'b1;

    run_one("add", 4'h2, 32'd5, 32'd3, 4'd1, 32'd8, 1'b0, 1'b0, 1'b0);
    chk("add_ops", ops_done, 8'd1);
    run_one("addovf", 4'h2, 32'h7FFF_FFFF, 32'd1, 4'd2, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub", 4'h6, 32'd5, 32'd5, 4'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    run_one("slt", 4'h7, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1, 1'b0, 1'b0, 1'b0);
    run_one("sll", 4'h8, 32'd1, 32'd31, 4'd5, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_one("srl", 4'h9, 32'h8000_0000, 32'd31, 4'd6, 32'd1, 1'b0, 1'b0, 1'b0);
    run_one("srlz", 4'h9, 32'd1, 32'd1, 4'd8, 32'd0, 1'b1, 1'b0, 1'b0);
    run_one("nor", 4'hC, 32'h0F0F_0000, 32'h0000_00FF, 4'd9, 32'hF0F0_FF00, 1'b0, 1'b0, 1'b0);
    run_one("ill", 4'hF, 32'd12, 32'd34, 4'd7, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("ill_ops", ops_done, 8'd9);

    // Backpressure: four offers, only two fit
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'h1, 32'h100 << i, 32'd1, 4'(10 + i));
      cycle();
    end
    chk("bp_held", q.size(), 2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_tag_hold", out_tag, 4'd10);
    in_valid = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b1;
    chk("bp_tag0", out_tag, 4'd10);
    cycle();
    chk("bp_tag1", out_tag, 4'd11);
    chk("bp_back2back", out_valid, 1'b1);
    cycle();
    chk("bp_drained", out_valid, 1'b0);

    // Reset while both stages are full and a new op is offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'h2, 32'(i), 32'd7, 4'(i));
      cycle();
    end
    rst_n = 1'b0; out_ready = 1'b1;
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_ops", ops_done, 8'd0);
    chk("mrst_in_ready", in_ready, 1'b1);
    repeat (4) cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_funct  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 8)];
      in_a      = pick();
      in_b      = pick();
      in_tag    = 4'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
